// File: rtl/vga_pride_pkg.sv
// vga_pride_pkg: shared flag-sequencer types and defaults, also consumed by the pixel renderer.
package vga_pride_pkg;
    localparam int NUM_FLAGS_DEF       = 24;
    localparam int DWELL_FRAMES_DEF    = 300;
    localparam int WIPE_FRAMES_DEF     = 32;
    localparam int DEBOUNCE_FRAMES_DEF = 3;
    localparam int FLAG_W_DEF          = $clog2(NUM_FLAGS_DEF);

    typedef logic [FLAG_W_DEF-1:0] flag_idx_t;
    typedef enum logic {SHOW, WIPE} seq_state_t;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser, frame-sampled stability counter and press-edge output.
module button_debounce #(
    parameter int FRAMES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start_i,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(FRAMES + 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          settle;

    // settle is true on the sample that completes a run of FRAMES differing samples
    assign settle  = (sync_q[1] != level_q) && (cnt_q == CW'(FRAMES - 1));
    assign press_o = frame_start_i && settle && sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            if (frame_start_i) begin
                if (sync_q[1] == level_q) cnt_q <= '0;
                else if (settle) begin
                    level_q <= sync_q[1];
                    cnt_q   <= '0;
                end else cnt_q <= cnt_q + CW'(1);
            end
        end
    end
endmodule

// File: rtl/vga_flag_sequencer.sv
// vga_flag_sequencer: frame-synchronous flag selection with dwell auto-advance, buttons,
// direct select and a left-to-right wipe between outgoing and incoming flags.
module vga_flag_sequencer
    import vga_pride_pkg::*;
#(
    parameter int NUM_FLAGS       = NUM_FLAGS_DEF,
    parameter int DWELL_FRAMES    = DWELL_FRAMES_DEF,
    parameter int WIPE_FRAMES     = WIPE_FRAMES_DEF,
    parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF,
    localparam int FLAG_W         = $clog2(NUM_FLAGS),
    localparam int WIPE_W         = $clog2(WIPE_FRAMES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              auto_en,
    input  logic              sel_valid,
    input  logic [FLAG_W-1:0] sel_idx,
    output logic [FLAG_W-1:0] cur_flag,
    output logic [FLAG_W-1:0] next_flag,
    output logic              wipe_active,
    output logic [WIPE_W-1:0] wipe_pos,
    output logic              flag_changed
);
    localparam int DW = $clog2(DWELL_FRAMES);
    localparam logic [FLAG_W-1:0] LAST = FLAG_W'(NUM_FLAGS - 1);

    seq_state_t        state_q;
    logic [FLAG_W-1:0] cur_q, nxt_q, pidx_q, fwd, bwd, go_idx;
    logic [WIPE_W-1:0] pos_q;
    logic [DW-1:0]     dwell_q;
    logic              act_q, chg_q, pend_q, press_next, press_prev, sel_ok, dwell_end, go;

    button_debounce #(.FRAMES(DEBOUNCE_FRAMES)) u_next (
        .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start), .btn_i(btn_next), .press_o(press_next)
    );
    button_debounce #(.FRAMES(DEBOUNCE_FRAMES)) u_prev (
        .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start), .btn_i(btn_prev), .press_o(press_prev)
    );

    // A pending select owns the frame even when it targets the current flag.
    always_comb begin
        fwd       = (cur_q == LAST) ? '0 : cur_q + FLAG_W'(1);
        bwd       = (cur_q == '0) ? LAST : cur_q - FLAG_W'(1);
        sel_ok    = sel_valid && (32'(sel_idx) < NUM_FLAGS);
        dwell_end = auto_en && (dwell_q == DW'(DWELL_FRAMES - 1));
        go        = pend_q ? (pidx_q != cur_q) : ((press_next ^ press_prev) || dwell_end);
        go_idx    = pend_q ? pidx_q : (press_prev && !press_next) ? bwd : fwd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SHOW;
            cur_q   <= '0;
            nxt_q   <= '0;
            pidx_q  <= '0;
            pos_q   <= '0;
            dwell_q <= '0;
            act_q   <= 1'b0;
            chg_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            chg_q <= 1'b0;
            if (frame_start) begin
                if (state_q == SHOW) begin
                    pend_q <= 1'b0;
                    if (go) begin
                        state_q <= WIPE;
                        nxt_q   <= go_idx;
                        act_q   <= 1'b1;
                        pos_q   <= '0;
                        dwell_q <= '0;
                    end else if (auto_en && !pend_q) dwell_q <= dwell_q + DW'(1);
                end else if (pos_q == WIPE_W'(WIPE_FRAMES - 1)) begin
                    state_q <= SHOW;
                    cur_q   <= nxt_q;
                    chg_q   <= 1'b1;
                    act_q   <= 1'b0;
                    pos_q   <= '0;
                    dwell_q <= '0;
                end else pos_q <= pos_q + WIPE_W'(1);
            end
            // a select arriving on an update cycle survives the consume above
            if (sel_ok) begin
                pend_q <= 1'b1;
                pidx_q <= sel_idx;
            end
        end
    end

    assign cur_flag     = cur_q;
    assign next_flag    = nxt_q;
    assign wipe_active  = act_q;
    assign wipe_pos     = pos_q;
    assign flag_changed = chg_q;
endmodule

// File: doc/vga_flag_sequencer.md
Name: vga_flag_sequencer

Overview:
Frame-synchronous controller that decides which pride flag the VGA renderer draws.
- Auto-cycles flags after a dwell time.
- Accepts debounced next/prev buttons and a direct-select request.
- Drives a left-to-right wipe transition: `wipe_pos` tells the renderer how far the incoming flag has replaced the outgoing one.
- Sits between the VGA timing generator (source of `frame_start`) and the pixel colour lookup.

Parameters:
- NUM_FLAGS, 24, number of selectable flags (≥2); FLAG_W = clog2(NUM_FLAGS), derived localparam.
- DWELL_FRAMES, 300, frames a flag is shown before auto-advance (≥2).
- WIPE_FRAMES, 32, transition length in frames; power of two ≥2; WIPE_W = clog2(WIPE_FRAMES).
- DEBOUNCE_FRAMES, 3, consecutive frame samples a button must be stable to register (≥1).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- btn_next  in  1  raw asynchronous button, active high
- btn_prev  in  1  raw asynchronous button, active high
- auto_en  in  1  enables dwell-timer auto-advance; level
- sel_valid  in  1  direct-select request, one-cycle pulse
- sel_idx  in  FLAG_W  flag index for direct select
- cur_flag  out  FLAG_W  outgoing/displayed flag
- next_flag  out  FLAG_W  incoming flag during wipe; equals cur_flag in SHOW
- wipe_active  out  1  high while in WIPE
- wipe_pos  out  WIPE_W  wipe progress, 0..WIPE_FRAMES-1
- flag_changed  out  1  one-cycle pulse when cur_flag updates

Behaviour:
- Reset (async assert, sync release): state=SHOW, cur_flag=0, next_flag=0, wipe_active=0, wipe_pos=0, flag_changed=0, dwell=0, debouncers cleared, pending select cleared. All outputs registered.
- Buttons: 2-flop synchroniser per button, then sampled only on frame_start. Debounced level flips after DEBOUNCE_FRAMES consecutive equal samples differing from the current level. A press event is the debounced 0→1 edge, one frame_start wide.
- sel_valid latches sel_idx into a pending register. A later sel_valid overwrites it. sel_idx ≥ NUM_FLAGS is ignored (pending not set).
- All state/output changes happen only in the cycle where frame_start=1 (no mid-frame tearing). flag_changed pulses in that same update cycle.
- SHOW, on frame_start, priority order:
  1. Pending select with idx≠cur_flag: next_flag=idx, enter WIPE, wipe_pos=0, clear pending. Idx==cur_flag: clear pending, no action.
  2. Exactly one press event: next=cur±1 with wrap (NUM_FLAGS-1→0, 0→NUM_FLAGS-1), enter WIPE. Both events in same frame: both discarded.
  3. auto_en and dwell==DWELL_FRAMES-1: advance +1 with wrap, enter WIPE.
  4. Otherwise dwell+=1 if auto_en, else dwell holds.
- Entering WIPE clears dwell.
- WIPE, on frame_start:
  - wipe_pos<WIPE_FRAMES-1: wipe_pos+=1.
  - wipe_pos==WIPE_FRAMES-1: cur_flag=next_flag, flag_changed=1, wipe_pos=0, wipe_active=0, state SHOW, dwell=0.
  - Press events during WIPE are dropped. sel_valid during WIPE stays pending and is served on the first SHOW frame_start.
- wipe_active is asserted in the update cycle that enters WIPE. wipe_pos=0 on the first wiped frame.
- auto_en deasserted mid-dwell freezes dwell; re-assertion resumes the count.
- Reset mid-wipe returns to flag 0 in SHOW immediately.

Decomposition:
- Package vga_pride_pkg holds:
  - NUM_FLAGS default constant
  - flag_idx_t typedef
  - seq_state_t enum {SHOW, WIPE}
  - WIPE_FRAMES/DWELL_FRAMES defaults shared with the renderer
- Sub-module button_debounce (2-flop sync + frame-sampled stability counter + press-edge output), instantiated twice.

Test Plan:
All scenarios use NUM_FLAGS=5, DWELL_FRAMES=4, WIPE_FRAMES=4, DEBOUNCE_FRAMES=2, short synthetic frames.
- Reset + auto_en=1, no buttons.
  - Frame 4: WIPE starts with next_flag=1.
  - 4 frames later: cur_flag=1, flag_changed pulses once.
  - Wrap check: cur 4→0.
- btn_prev held 2 frames from cur_flag=0, auto_en=0: next_flag=4, wipe_pos runs 0,1,2,3, then cur_flag=4.
- btn_next 1-frame glitch (held one sample only): no press event, cur_flag unchanged, dwell unaffected.
- btn_next and btn_prev press on same frame: no WIPE. During WIPE, a press is dropped (cur advances exactly once).
- sel_valid idx=3 during WIPE to 1: after wipe completes cur=1, next frame_start starts WIPE to 3. idx=7: ignored. idx==cur_flag: no wipe.
- Assert rst_n=0 with wipe_pos=2: outputs immediately cur=0, next=0, wipe_active=0, wipe_pos=0, without a clock edge.
